// File: rtl/fetch_unit_pkg.sv
// Shared fetch-pipeline types and constants: FSM state encoding, NOP word, default reset PC.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] pc_add(input logic [31:0] pc, input logic [31:0] inc);
        return pc + inc;
    endfunction

endpackage

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register: flush > redirect-kill > stall > load; an unstalled cycle without a load inserts a bubble.
// Latency one edge; i_stall freezes all three outputs unless a flush or kill overrides it.
module fetch_ifid_reg
    import fetch_unit_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_flush,
    input  logic        i_kill,
    input  logic        i_stall,
    input  logic        i_load,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc8,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc8,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc8;
    logic        r_valid;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_instr <= NOP_INSTR;
            r_pc8   <= 32'h0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_kill) begin
            r_valid <= 1'b0;
        end else if (!i_stall) begin
            if (i_load) begin
                r_instr <= i_instr;
                r_pc8   <= i_pc8;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_instr = r_instr;
    assign o_pc8   = r_pc8;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: request FSM (S_REQ/S_HOLD/S_DROP) with a one-word skid register; InstrD is valid the edge after ImemAck.
// StallD parks an acked word in the skid register; FETCH_PERF_CNT_EN adds FetchCountD/ImemWaitCount counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        BranchTakenE,
    input  logic [31:0] BranchTargetE,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemRData,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus8D,
    output logic        ValidD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] FetchCountD,
    output logic [31:0] ImemWaitCount
`endif
);

    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_pcf, w_pcf_nxt;
    logic [31:0]  r_stale, w_stale_nxt;
    logic [31:0]  r_skid_instr, r_skid_pc;
    logic         r_run;
    logic         w_ack, w_load, w_kill, w_skid_we;
    logic [31:0]  w_load_instr, w_load_pc8;

    // r_run keeps the bus idle until the first edge after reset releases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_REQ;
            r_pcf        <= RESET_PC;
            r_stale      <= 32'h0;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc    <= 32'h0;
            r_run        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pcf   <= w_pcf_nxt;
            r_stale <= w_stale_nxt;
            r_run   <= 1'b1;
            if (w_skid_we) begin
                r_skid_instr <= ImemRData;
                r_skid_pc    <= r_pcf;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pcf_nxt    = r_pcf;
        w_stale_nxt  = r_stale;
        w_load       = 1'b0;
        w_kill       = 1'b0;
        w_skid_we    = 1'b0;
        w_load_instr = ImemRData;
        w_load_pc8   = pc_add(r_pcf, 32'd8);
        ImemReq      = r_run && (r_state != S_HOLD);
        ImemAddr     = (r_state == S_DROP) ? r_stale : r_pcf;
        w_ack        = ImemAck && ImemReq;

        unique case (r_state)
            S_REQ: begin
                if (BranchTakenE) begin
                    w_pcf_nxt = BranchTargetE;
                    w_kill    = 1'b1;
                    // The outstanding request must still complete on the bus; remember it.
                    if (!w_ack) begin
                        w_stale_nxt = r_pcf;
                        w_state_nxt = S_DROP;
                    end
                end else if (w_ack) begin
                    if (StallD) begin
                        w_skid_we   = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_load    = 1'b1;
                        w_pcf_nxt = pc_add(r_pcf, 32'd4);
                    end
                end
            end
            S_HOLD: begin
                if (BranchTakenE) begin
                    w_pcf_nxt   = BranchTargetE;
                    w_kill      = 1'b1;
                    w_state_nxt = S_REQ;
                end else if (!StallD) begin
                    w_load       = 1'b1;
                    w_load_instr = r_skid_instr;
                    w_load_pc8   = pc_add(r_skid_pc, 32'd8);
                    w_pcf_nxt    = pc_add(r_pcf, 32'd4);
                    w_state_nxt  = S_REQ;
                end
            end
            S_DROP: begin
                if (BranchTakenE) begin
                    w_pcf_nxt = BranchTargetE;
                end
                if (w_ack) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    fetch_ifid_reg u_ifid (
        .i_clk   (clk),
        .i_reset (reset),
        .i_flush (FlushD),
        .i_kill  (w_kill),
        .i_stall (StallD),
        .i_load  (w_load),
        .i_instr (w_load_instr),
        .i_pc8   (w_load_pc8),
        .o_instr (InstrD),
        .o_pc8   (PCPlus8D),
        .o_valid (ValidD)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_wait_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_cnt <= 32'h0;
            r_wait_cnt  <= 32'h0;
        end else begin
            if (w_load && !FlushD) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (ImemReq && !ImemAck) begin
                r_wait_cnt <= r_wait_cnt + 32'd1;
            end
        end
    end

    assign FetchCountD   = r_fetch_cnt;
    assign ImemWaitCount = r_wait_cnt;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 StallD  input  1  decode stage holding; IF/ID must not change.
REQ-005 FlushD  input  1  hazard-unit flush of IF/ID.
REQ-006 BranchTakenE  input  1  redirect request from execute.
REQ-007 BranchTargetE  input  32  redirect target: PC+8 plus sign-extended shifted branch offset.
REQ-008 ImemReq  output  1  instruction-memory request.
REQ-009 ImemAddr  output  32  word address of the request.
REQ-010 ImemAck  input  1  one-cycle response strobe; data is valid the same cycle.
REQ-011 ImemRData  input  32  fetched instruction.
REQ-012 InstrD  output  32  IF/ID instruction; bits [23:0] feed the immediate extender.
REQ-013 PCPlus8D  output  32  fetch address + 8 for the D-stage instruction.
REQ-014 ValidD  output  1  InstrD holds a real instruction.

Function
REQ-015 The FSM SHALL have three states: S_REQ, S_HOLD and S_DROP.
- S_REQ: ImemReq=1, ImemAddr=PCF.
- S_HOLD: ImemReq=0; the fetched word is parked in the skid register.
- S_DROP: ImemReq=1, ImemAddr=stale address; waiting to discard the response.
REQ-016 ImemAddr and ImemReq SHALL stay stable from assertion until ImemAck.
REQ-017 In S_REQ with ImemAck and !StallD, the block SHALL load InstrD=ImemRData, PCPlus8D=PCF+8 and ValidD=1, set PCF+=4, and stay in S_REQ.
REQ-018 In S_REQ with ImemAck and StallD, the block SHALL latch ImemRData and PCF into the skid register and go to S_HOLD.
REQ-019 In S_HOLD with !StallD, the block SHALL move the skid contents into IF/ID, set PCF+=4, and go to S_REQ.
REQ-020 BranchTakenE SHALL set PCF=BranchTargetE, discard any held or same-cycle response, and set ValidD=0.
- Redirect in S_REQ with no ack: save the stale address and go to S_DROP.
- Redirect in any other case: go to S_REQ.
REQ-021 In S_DROP, ImemAck SHALL be consumed without an IF/ID write, then the FSM goes to S_REQ at PCF.
REQ-022 A BranchTakenE in S_DROP SHALL only update PCF.
REQ-023 FlushD SHALL force InstrD=32'h0 and ValidD=0, with priority over StallD and over any load.
REQ-024 With StallD=1 and no flush or redirect, InstrD, PCPlus8D and ValidD SHALL hold their values.
REQ-025 All PC arithmetic SHALL be modulo 2^32; PCF=32'hFFFF_FFFC wraps to 32'h0.
REQ-026 Fetch latency SHALL be ImemAck cycle + 1: InstrD is valid on the edge after the ack.

Reset
REQ-027 Reset SHALL asynchronously set PCF=RESET_PC, state=S_REQ, InstrD=0, PCPlus8D=0, ValidD=0, and clear the skid register.
REQ-028 An ack arriving while reset is asserted SHALL be ignored.
REQ-029 The first request SHALL issue on the first edge after reset deasserts.

Configuration
REQ-030 With FETCH_PERF_CNT_EN defined, the block SHALL add outputs FetchCountD[31:0] and ImemWaitCount[31:0].
- FetchCountD increments on each IF/ID load with ValidD=1.
- ImemWaitCount increments each cycle ImemReq=1 and ImemAck=0.
- Both counters wrap, and reset clears them.
REQ-031 Without FETCH_PERF_CNT_EN, those ports and their logic SHALL be absent.

Structure
REQ-032 The shared pipeline package SHALL hold the FSM state typedef, NOP_INSTR=32'h0 and the default RESET_PC constant.
REQ-033 The IF/ID register, with stall/flush/load priority, SHALL be the sub-module fetch_ifid_reg; the FSM and PC logic stay in fetch_unit.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- Reset with RESET_PC=0x100, ack every cycle, words 0xE3A01005, 0xE2811001 -> ImemAddr 0x100, 0x104; InstrD 0xE3A01005 then 0xE2811001; PCPlus8D 0x108 then 0x10C.
- Ack at 0x200 while StallD=1 for 3 cycles -> S_HOLD, ImemReq=0, InstrD unchanged; after release InstrD=ack data and the next request is at 0x204.
- Redirect to 0x400 while a request at 0x20C awaits ack for 2 cycles -> ImemAddr stays 0x20C until ack, no IF/ID write, then a request at 0x400.
- FlushD and StallD together -> InstrD=0, ValidD=0.
- RESET_PC=0xFFFF_FFFC -> the second request is at 0x0 and PCPlus8D=0x4.
- With FETCH_PERF_CNT_EN, 4 loads and 2 wait cycles -> FetchCountD=4 and ImemWaitCount=2.
